dmem_arbiter: RTL

- Shares the single data-memory port (9-bit byte address, 32-bit data, Funct3 size code, MemRead/MemWrite strobes, one-cycle read) between two requesters:
  - the pipeline MEM stage (core);
  - a DMA/loader port (dma).
- Core has fixed priority. A starvation counter guarantees DMA progress.
- One registered command stage drives the memory. Read data returns registered to the requester that issued the read.

---
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// One requester's data-memory channel: command toward the arbiter, accept
// strobe and registered load data back toward the requester.
interface dmem_arbiter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req;
   logic                  we;
   logic [DM_ADDRESS-1:0] addr;
   logic [DATA_W-1:0]     wdata;
   logic [2:0]            funct3;
   logic                  ready;
   logic [DATA_W-1:0]     rdata;
   logic                  rvalid;

   modport master (
      output req, we, addr, wdata, funct3,
      input  ready, rdata, rvalid
   );

   modport slave (
      input  req, we, addr, wdata, funct3,
      output ready, rdata, rvalid
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: fixed core priority with a starvation
// counter for the DMA port, one registered command stage, per-owner read return.
module dmem_arbiter #(
   parameter int DM_ADDRESS   = 9,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dmem_arbiter_if.slave         core,
   dmem_arbiter_if.slave         dma,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_a,
   output logic [DATA_W-1:0]     mem_wd,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_W-1:0]     mem_rd
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam int               N_REQ = 2;

   typedef enum logic {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_e;

   owner_e                owner_reg, owner_next;
   logic [CNT_W-1:0]      starve_cnt_reg, starve_cnt_next;
   logic                  mem_read_reg, mem_read_next;
   logic                  mem_write_reg, mem_write_next;
   logic [DM_ADDRESS-1:0] mem_a_reg, mem_a_next;
   logic [DATA_W-1:0]     mem_wd_reg, mem_wd_next;
   logic [2:0]            mem_funct3_reg, mem_funct3_next;
   logic                  force_dma, grant_dma, grant_core;

   // Return path indexed by owner encoding: 0 = core, 1 = dma.
   logic [DATA_W-1:0]     rdata_reg [N_REQ];
   logic                  rvalid_reg [N_REQ];

   always_comb begin
      force_dma  = dma.req && (starve_cnt_reg == LIMIT);
      grant_dma  = dma.req && (!core.req || force_dma);
      grant_core = core.req && !grant_dma;
   end

   // Ready is held low while reset is asserted even if a request is pending.
   assign core.ready = grant_core && rst_n;
   assign dma.ready  = grant_dma && rst_n;

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      owner_next      = owner_reg;
      mem_read_next   = 1'b0;
      mem_write_next  = 1'b0;
      mem_a_next      = mem_a_reg;
      mem_wd_next     = mem_wd_reg;
      mem_funct3_next = mem_funct3_reg;

      if (!dma.req || grant_dma) begin
         starve_cnt_next = '0;
      end else if (starve_cnt_reg != LIMIT) begin
         starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end

      if (grant_dma) begin
         owner_next      = OWN_DMA;
         mem_read_next   = !dma.we;
         mem_write_next  = dma.we;
         mem_a_next      = dma.addr;
         mem_wd_next     = dma.wdata;
         mem_funct3_next = dma.funct3;
      end else if (grant_core) begin
         owner_next      = OWN_CORE;
         mem_read_next   = !core.we;
         mem_write_next  = core.we;
         mem_a_next      = core.addr;
         mem_wd_next     = core.wdata;
         mem_funct3_next = core.funct3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_reg      <= OWN_CORE;
         starve_cnt_reg <= '0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         mem_a_reg      <= '0;
         mem_wd_reg     <= '0;
         mem_funct3_reg <= '0;
      end else begin
         owner_reg      <= owner_next;
         starve_cnt_reg <= starve_cnt_next;
         mem_read_reg   <= mem_read_next;
         mem_write_reg  <= mem_write_next;
         mem_a_reg      <= mem_a_next;
         mem_wd_reg     <= mem_wd_next;
         mem_funct3_reg <= mem_funct3_next;
      end
   end

   assign mem_read   = mem_read_reg;
   assign mem_write  = mem_write_reg;
   assign mem_a      = mem_a_reg;
   assign mem_wd     = mem_wd_reg;
   assign mem_funct3 = mem_funct3_reg;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ret
         logic hit;
         assign hit = mem_read_reg && (owner_reg == owner_e'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rvalid_reg[gi] <= 1'b0;
               rdata_reg[gi]  <= '0;
            end else begin
               rvalid_reg[gi] <= hit;
               if (hit) begin
                  rdata_reg[gi] <= mem_rd;
               end
            end
         end
      end
   endgenerate

   assign core.rdata  = rdata_reg[0];
   assign core.rvalid = rvalid_reg[0];
   assign dma.rdata   = rdata_reg[1];
   assign dma.rvalid  = rvalid_reg[1];
endmodule
